// File: rtl/scrambler_key_gen_pkg.sv
// Shared types and constants for the per-line scrambler key generator.
// Holds FSM encoding, LFSR defaults and the seed fold helper.
package scrambler_key_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_POLY   = 32'h8020_0003;
   localparam int          STEPS_PER_LINE = 8;
   localparam logic [31:0] ZERO_SEED_SUB  = 32'h0000_0001;

   // An all-zero LFSR would lock up, so a zero fold is replaced.
   function automatic logic [31:0] fold_seed(input logic [255:0] seed);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f = f ^ seed[i*32 +: 32];
      end
      return (f == '0) ? ZERO_SEED_SUB : f;
   endfunction

endpackage

// File: rtl/scrambler_lfsr32.sv
// 32-bit right-shift Galois LFSR with folded-seed load.
// Load has priority over step.
module scrambler_lfsr32
   import scrambler_key_gen_pkg::*;
#(
   parameter logic [31:0] LFSR_POLY = DEFAULT_POLY
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [255:0] seed,
   input  logic         step,
   output logic [31:0]  lfsr
);

   logic [31:0] lfsr_q;
   logic [31:0] stepped;

   assign stepped = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY)
                              : (lfsr_q >> 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= ZERO_SEED_SUB;
      end else if (load) begin
         lfsr_q <= fold_seed(seed);
      end else if (step) begin
         lfsr_q <= stepped;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/scrambler_key_gen.sv
// Per-line scrambler key generator: eight LFSR steps per request,
// then a cut point reduced below CUT_MAX.
module scrambler_key_gen
   import scrambler_key_gen_pkg::*;
#(
   parameter int unsigned CUT_MAX   = 200,
   parameter logic [31:0] LFSR_POLY = DEFAULT_POLY
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] seed,
   input  logic         seed_load,
   input  logic         MODE,
   input  logic         line_req,
   output logic         busy,
   output logic         key_valid,
   output logic [7:0]   cut_point,
   output logic         req_overrun
);

   localparam logic [7:0] CUT_MAX_B = 8'(CUT_MAX);
   localparam logic [2:0] LAST_CNT  = 3'(STEPS_PER_LINE - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        step;
   logic [31:0] lfsr;
   logic [7:0]  b;
   logic [7:0]  cut_calc;
   logic        done_fire;
   logic        unused_hi;

   scrambler_lfsr32 #(
      .LFSR_POLY (LFSR_POLY)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (seed_load),
      .seed  (seed),
      .step  (step),
      .lfsr  (lfsr)
   );

   assign b         = lfsr[7:0];
   assign unused_hi = ^lfsr[31:8];
   assign cut_calc  = (b < CUT_MAX_B) ? b : (b - CUT_MAX_B);
   assign done_fire = (state_q == ST_DONE) && !seed_load;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step    = 1'b0;
      if (seed_load) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (line_req) begin
                  state_d = ST_STEP;
                  cnt_d   = '0;
               end
            end
            ST_STEP: begin
               step = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         key_valid   <= 1'b0;
         cut_point   <= '0;
         req_overrun <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_valid <= done_fire;
         // Bypass still consumes the key so both ends stay in step.
         if (done_fire) begin
            cut_point <= MODE ? cut_calc : 8'd0;
         end
         if (seed_load) begin
            req_overrun <= 1'b0;
         end else if (line_req && state_q != ST_IDLE) begin
            req_overrun <= 1'b1;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scrambler_key_gen.sv
// Directed bench for scrambler_key_gen with hand-computed key values.
module tb_scrambler_key_gen;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] seed;
   logic         seed_load;
   logic         MODE;
   logic         line_req;
   logic         busy, key_valid, req_overrun;
   logic [7:0]   cut_point;
   logic         busy2, key_valid2, req_overrun2;
   logic [7:0]   cut_point2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   scrambler_key_gen dut (
      .clk         (clk),
      .reset       (reset),
      .seed        (seed),
      .seed_load   (seed_load),
      .MODE        (MODE),
      .line_req    (line_req),
      .busy        (busy),
      .key_valid   (key_valid),
      .cut_point   (cut_point),
      .req_overrun (req_overrun)
   );

   scrambler_key_gen #(.CUT_MAX(128)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .seed        (seed),
      .seed_load   (seed_load),
      .MODE        (MODE),
      .line_req    (line_req),
      .busy        (busy2),
      .key_valid   (key_valid2),
      .cut_point   (cut_point2),
      .req_overrun (req_overrun2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic get_key(input string tag, output logic [7:0] cut,
                          output logic [7:0] cut2);
      int lat;
      int bcnt;
      line_req = 1'b1;
      tick();
      line_req = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!key_valid && lat < 20) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, 9);
      chk({tag, "_busy_cycles"}, bcnt, 9);
      chk({tag, "_busy_low"}, {31'd0, busy}, 0);
      cut  = cut_point;
      cut2 = cut_point2;
      tick();
      chk({tag, "_kv_single"}, {31'd0, key_valid}, 0);
   endtask

   task automatic watch_kv(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         tick();
         if (key_valid) pulses++;
      end
   endtask

   task automatic do_load(input logic [255:0] s);
      seed      = s;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
   endtask

   logic [7:0]   c, c2;
   int           np;
   logic [255:0] s_fold0, s_fold4;

   initial begin
      reset     = 1'b1;
      seed      = '0;
      seed_load = 1'b0;
      MODE      = 1'b1;
      line_req  = 1'b0;
      s_fold0   = '0;
      s_fold0[31:0]  = 32'h1234_5678;
      s_fold0[63:32] = 32'h1234_5678;
      s_fold4   = '0;
      s_fold4[95:64]   = 32'h0000_000C;
      s_fold4[191:160] = 32'h0000_0008;

      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_kv", {31'd0, key_valid}, 0);
      chk("rst_cut", {24'd0, cut_point}, 0);
      chk("rst_ovr", {31'd0, req_overrun}, 0);
      chk("rst_lfsr", dut.lfsr, 32'h0000_0001);
      reset = 1'b0;

      do_load('0);
      chk("load0_lfsr", dut.lfsr, 32'h0000_0001);
      get_key("k1", c, c2);
      chk("k1_cut", {24'd0, c}, 2);
      chk("k1_cut128", {24'd0, c2}, 2);
      chk("k1_lfsr", dut.lfsr, 32'hDB36_C002);
      tick();
      tick();
      chk("k1_cut_hold", {24'd0, cut_point}, 2);
      get_key("k2", c, c2);
      chk("k2_cut", {24'd0, c}, 195);
      chk("k2_cut128", {24'd0, c2}, 67);
      chk("k2_lfsr", dut.lfsr, 32'hB6F6_B6C3);
      get_key("k3", c, c2);
      chk("k3_cut", {24'd0, c}, 182);
      chk("k3_lfsr", dut.lfsr, 32'h2DBD_B6B6);

      do_load(s_fold0);
      chk("fold0_lfsr", dut.lfsr, 32'h0000_0001);
      get_key("f1", c, c2);
      chk("f1_cut", {24'd0, c}, 2);
      get_key("f2", c, c2);
      chk("f2_cut", {24'd0, c}, 195);

      MODE = 1'b0;
      do_load('0);
      get_key("m1", c, c2);
      chk("m1_cut", {24'd0, c}, 0);
      get_key("m2", c, c2);
      chk("m2_cut", {24'd0, c}, 0);
      chk("m2_lfsr", dut.lfsr, 32'hB6F6_B6C3);
      MODE = 1'b1;
      get_key("m3", c, c2);
      chk("m3_cut", {24'd0, c}, 182);

      do_load('0);
      line_req = 1'b1;
      tick();
      line_req = 1'b0;
      tick();
      tick();
      tick();
      line_req = 1'b1;
      tick();
      line_req = 1'b0;
      chk("ovr_set", {31'd0, req_overrun}, 1);
      chk("ovr_busy", {31'd0, busy}, 1);
      watch_kv(20, np);
      chk("ovr_kv_count", np, 1);
      chk("ovr_cut", {24'd0, cut_point}, 2);
      chk("ovr_sticky", {31'd0, req_overrun}, 1);
      do_load('0);
      chk("ovr_cleared", {31'd0, req_overrun}, 0);

      seed      = s_fold4;
      seed_load = 1'b1;
      line_req  = 1'b1;
      tick();
      seed_load = 1'b0;
      line_req  = 1'b0;
      chk("coinc_busy", {31'd0, busy}, 0);
      chk("coinc_ovr", {31'd0, req_overrun}, 0);
      chk("coinc_lfsr", dut.lfsr, 32'h0000_0004);
      watch_kv(12, np);
      chk("coinc_no_kv", np, 0);

      line_req = 1'b1;
      tick();
      line_req = 1'b0;
      tick();
      tick();
      seed      = s_fold4;
      seed_load = 1'b1;
      line_req  = 1'b1;
      tick();
      seed_load = 1'b0;
      line_req  = 1'b0;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_ovr", {31'd0, req_overrun}, 0);
      chk("abort_lfsr", dut.lfsr, 32'h0000_0004);
      chk("abort_cut_kept", {24'd0, cut_point}, 2);
      watch_kv(12, np);
      chk("abort_no_kv", np, 0);
      get_key("s4", c, c2);
      chk("s4_cut", {24'd0, c}, 1);
      chk("s4_lfsr", dut.lfsr, 32'h6C1B_0001);

      line_req = 1'b1;
      tick();
      line_req = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rmid_busy", {31'd0, busy}, 0);
      chk("rmid_kv", {31'd0, key_valid}, 0);
      chk("rmid_lfsr", dut.lfsr, 32'h0000_0001);
      chk("rmid_cut", {24'd0, cut_point}, 0);
      watch_kv(12, np);
      chk("rmid_no_kv", np, 0);

      reset     = 1'b1;
      seed      = s_fold4;
      seed_load = 1'b1;
      line_req  = 1'b1;
      tick();
      reset     = 1'b0;
      seed_load = 1'b0;
      line_req  = 1'b0;
      chk("rprio_lfsr", dut.lfsr, 32'h0000_0001);
      chk("rprio_busy", {31'd0, busy}, 0);
      get_key("r1", c, c2);
      chk("r1_cut", {24'd0, c}, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/scrambler_key_gen.md
SCRAMBLER_KEY_GEN -- requirements
Module: scrambler_key_gen

Interface
REQ-001 Parameter CUT_MAX, default 200, exclusive upper bound of cut_point; legal range 128..255.
REQ-002 Parameter LFSR_POLY, default 32'h80200003, right-shift Galois toggle mask.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seed  input  256  key from ROM reader; sampled only on seed_load.
REQ-006 seed_load  input  1  one-cycle pulse: load seed, abort any key generation in progress.
REQ-007 MODE  input  1  1 = scramble, 0 = bypass; sampled in DONE state.
REQ-008 line_req  input  1  one-cycle pulse requesting the next per-line key.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 key_valid  output  1  one-cycle pulse; cut_point valid while high.
REQ-011 cut_point  output  8  line cut/rotate position, 0..CUT_MAX-1.
REQ-012 req_overrun  output  1  sticky flag: line_req arrived while busy.

Function
REQ-013 Seed fold: fold = XOR of the eight 32-bit words of seed; if fold == 0, lfsr loads 32'h00000001, else it loads fold.
REQ-014 LFSR step: if lfsr[0]=1, lfsr <= (lfsr>>1) ^ LFSR_POLY; else lfsr <= lfsr>>1.
REQ-015 FSM states: IDLE, STEP, DONE; 3-bit step counter cnt.
REQ-016 IDLE: line_req=1 at edge N -> STEP with cnt=0; otherwise hold.
REQ-017 STEP: one LFSR step per edge at edges N+1..N+8; at the edge where cnt==7 -> DONE; else cnt increments.
REQ-018 DONE, at edge N+9: register cut_point and key_valid=1 -> IDLE; key_valid is high for exactly the cycle after edge N+9; total latency 9 cycles.
REQ-019 Cut arithmetic, 8-bit: b = lfsr[7:0]; cut_point = b if b < CUT_MAX, else b - CUT_MAX.
REQ-020 MODE=0 in DONE: cut_point = 0, key_valid still pulses; LFSR advances identically so scrambler/descrambler stay in sync.
REQ-021 cut_point holds its last value between key_valid pulses.
REQ-022 line_req while busy: ignored, no queueing; req_overrun <= 1 and stays set until reset or seed_load.
REQ-023 seed_load in any state: lfsr loaded per REQ-013, state -> IDLE, cnt=0, key_valid=0, req_overrun=0, cut_point unchanged.
REQ-024 seed_load and line_req on the same edge: seed_load wins, line_req dropped, overrun not flagged.
REQ-025 No LFSR step is taken outside STEP, except the load of REQ-023.

Reset
REQ-026 reset=1 at an edge: state=IDLE, cnt=0, lfsr=32'h00000001, key_valid=0, cut_point=0, req_overrun=0, busy=0.
REQ-027 Reset overrides seed_load and line_req on the same edge.
REQ-028 Reset mid-STEP discards the partial key and no key_valid follows.

Structure
REQ-029 A shared package holds the state encoding (IDLE/STEP/DONE), the default LFSR_POLY, STEPS_PER_LINE=8 and the 32'h00000001 zero-seed substitute.
REQ-030 One sub-module, scrambler_lfsr32: load and step of the Galois LFSR, with a fold/zero-substitute on load.

Verification
REQ-031 Reset, then seed_load with seed=0, then line_req -> busy for 9 cycles, key_valid 9 cycles after request, cut_point=2 (lfsr=32'hDB36C002).
REQ-032 Second line_req after REQ-031 -> lfsr=32'hB6F6B6C3, cut_point=195; with CUT_MAX=128 -> cut_point=67.
REQ-033 seed words 0 and 1 = 32'h12345678, rest 0 (fold=0) -> same key sequence as REQ-031 (2, 195).
REQ-034 MODE=0 through the REQ-031/032 sequence -> cut_point=0 both times; switching to MODE=1 on the third request gives the same value as the third request of an all-MODE=1 run.
REQ-035 line_req at cycle 4 of STEP -> req_overrun=1, single key_valid only; seed_load clears req_overrun.
REQ-036 seed_load coincident with line_req, and reset asserted mid-STEP -> no key_valid, busy=0 next cycle, lfsr equals fold (or 1 on reset).
